// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream and RAM port bundle for the program loader
interface prog_loader_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5
);
    // host byte stream
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_valid;
    logic                     in_ready;
    // shared RAM port
    logic [ADDRESS_WIDTH-1:0] mem_add;
    logic [DATA_WIDTH-1:0]    mem_data_w;
    logic                     mem_wr;
    logic                     mem_rd;
    logic [DATA_WIDTH-1:0]    mem_data_r;

    // loader side
    modport master (
        input  in_data, in_valid, mem_data_r,
        output in_ready, mem_add, mem_data_w, mem_wr, mem_rd
    );

    // host source and RAM side
    modport slave (
        output in_data, in_valid, mem_data_r,
        input  in_ready, mem_add, mem_data_w, mem_wr, mem_rd
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a checksummed image into RAM, verifies it, then releases the CPU
module prog_loader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 cpu_halt,
    prog_loader_if.master        bus,
    output logic                 cpu_n_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [DATA_WIDTH-1:0]    DEPTH_D  = DATA_WIDTH'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, LEN, LOAD, CHK, VERIFY, RUN, ERROR
    } state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH:0]   count;      // image length N, held for the whole load and verify
    logic [ADDRESS_WIDTH-1:0] widx;       // address of the next payload byte
    logic [DATA_WIDTH-1:0]    sum;        // running payload sum from the stream
    logic [DATA_WIDTH-1:0]    vsum;       // running sum of words read back from RAM
    logic                     rd_pending; // a read was issued last cycle; its data is on mem_data_r now

    logic                     accept;
    logic                     go_len;
    logic                     last_w;
    logic                     last_rd;
    logic [DATA_WIDTH-1:0]    chk_total;
    logic [DATA_WIDTH-1:0]    vsum_next;

    assign accept    = bus.in_valid & bus.in_ready;
    // a new load may begin from IDLE, from ERROR, or from RUN only while the CPU is halted
    assign go_len    = start & ((state == IDLE) | (state == ERROR) | ((state == RUN) & cpu_halt));
    assign last_w    = ({1'b0, widx} == (count - CNT_ONE));
    assign last_rd   = ({1'b0, bus.mem_add} == (count - CNT_ONE));
    assign chk_total = sum + bus.in_data;
    assign vsum_next = vsum + bus.mem_data_r;

    // loader state machine; every output is a register updated here
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            cpu_n_rst      <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.mem_wr     <= 1'b0;
            bus.mem_rd     <= 1'b0;
            bus.mem_add    <= '0;
            bus.mem_data_w <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_code       <= 2'd0;
            sum            <= '0;
            count          <= '0;
            widx           <= '0;
            vsum           <= '0;
            rd_pending     <= 1'b0;
        end else begin
            bus.mem_wr <= 1'b0;
            rd_pending <= bus.mem_rd;
            if (go_len) begin
                state        <= LEN;
                bus.in_ready <= 1'b1;
                busy         <= 1'b1;
                cpu_n_rst    <= 1'b0;
                done         <= 1'b0;
                err          <= 1'b0;
                err_code     <= 2'd0;
            end else begin
                case (state)
                    LEN: begin
                        if (accept) begin
                            if (bus.in_data == '0 || bus.in_data > DEPTH_D) begin
                                state        <= ERROR;
                                bus.in_ready <= 1'b0;
                                busy         <= 1'b0;
                                err          <= 1'b1;
                                err_code     <= 2'd1;
                            end else begin
                                state <= LOAD;
                                count <= bus.in_data[ADDRESS_WIDTH:0];
                                widx  <= '0;
                                sum   <= '0;
                            end
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            bus.mem_wr     <= 1'b1;
                            bus.mem_add    <= widx;
                            bus.mem_data_w <= bus.in_data;
                            sum            <= sum + bus.in_data;
                            widx           <= widx + ADDR_ONE;
                            if (last_w) begin
                                state <= CHK;
                            end
                        end
                    end
                    CHK: begin
                        if (accept) begin
                            bus.in_ready <= 1'b0;
                            if (chk_total != '0) begin
                                state    <= ERROR;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                                err_code <= 2'd2;
                            end else begin
                                state       <= VERIFY;
                                bus.mem_rd  <= 1'b1;
                                bus.mem_add <= '0;
                                vsum        <= '0;
                            end
                        end
                    end
                    VERIFY: begin
                        if (bus.mem_rd) begin
                            if (last_rd) begin
                                bus.mem_rd <= 1'b0;
                            end else begin
                                bus.mem_add <= bus.mem_add + ADDR_ONE;
                            end
                        end
                        if (rd_pending) begin
                            vsum <= vsum_next;
                            // no read in flight any more: this is the last returned word
                            if (!bus.mem_rd) begin
                                busy <= 1'b0;
                                if (vsum_next == sum) begin
                                    state     <= RUN;
                                    cpu_n_rst <= 1'b1;
                                    done      <= 1'b1;
                                end else begin
                                    state    <= ERROR;
                                    err      <= 1'b1;
                                    err_code <= 2'd3;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Program loader for the 8-bit accumulator CPU. It is the write-side counterpart of the CPU's memory fetch path. It accepts a byte stream over a valid/ready handshake and writes the program image into the shared RAM from address 0 upward. It then reads the image back to verify it, and only then releases the CPU from reset. It sits between a host byte source and the RAM port, muxed ahead of the CPU's address/data lines while the CPU is held in reset.

Parameters:
DATA_WIDTH, 8, width of a RAM word and of a stream byte
ADDRESS_WIDTH, 5, RAM address width; DEPTH = 2**ADDRESS_WIDTH words (32)

Ports:
clk  input  1  clock, rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load
cpu_halt  input  1  CPU halt indication; reload is permitted only while high in RUN
in_data  input  DATA_WIDTH  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte
mem_add  output  ADDRESS_WIDTH  RAM address
mem_data_w  output  DATA_WIDTH  RAM write data
mem_wr  output  1  RAM write strobe
mem_rd  output  1  RAM read strobe
mem_data_r  input  DATA_WIDTH  RAM read data, valid 1 cycle after mem_rd
cpu_n_rst  output  1  active-low reset to the CPU
busy  output  1  load or verify in progress
done  output  1  image loaded and verified; CPU running
err  output  1  load failed
err_code  output  2  1 = bad length, 2 = checksum fail, 3 = verify mismatch, 0 = none

Behaviour:
- Reset (async, n_rst low) forces these values: state IDLE; cpu_n_rst=0; in_ready=0; mem_wr=0; mem_rd=0; mem_add=0; mem_data_w=0; busy=0; done=0; err=0; err_code=0; internal sum=0, count=0.
- A byte is accepted on a cycle where in_valid & in_ready. in_valid may drop at any time; no byte is lost or duplicated across gaps.
- Stream format: one length byte N (1..DEPTH), then N payload bytes, then one checksum byte C. The stream is valid when (sum of payload + C) mod 256 == 0.
- States and transitions:
  - IDLE: start -> LEN.
  - LEN: in_ready=1, busy=1, cpu_n_rst=0. On accept: if N==0 or N>DEPTH -> ERROR with err_code=1. Otherwise latch N into an (ADDRESS_WIDTH+1)-bit count, set addr=0 and sum=0 -> LOAD.
  - LOAD: in_ready=1. The k-th accepted byte produces mem_wr=1 for exactly one cycle on the following cycle, with mem_add=k and mem_data_w=byte. sum += byte (8-bit wrap). After the N-th byte -> CHK. mem_add equals DEPTH-1 at most; it never wraps to 0 within a load.
  - CHK: in_ready=1. On accept: if (sum + C)[7:0] != 0 -> ERROR with err_code=2. Otherwise -> VERIFY.
  - VERIFY: in_ready=0. Issues mem_rd on consecutive cycles for addresses 0..N-1, one per cycle. Each returned word is accumulated into vsum one cycle after its read. The state takes N+1 cycles. After the final accumulate: vsum == sum -> RUN, otherwise -> ERROR with err_code=3.
  - RUN: cpu_n_rst=1, done=1, busy=0. start is ignored while cpu_halt=0. start with cpu_halt=1 -> LEN, which re-asserts cpu_n_rst=0 on the same transition and clears done.
  - ERROR: err=1, cpu_n_rst=0, busy=0. start -> LEN and clears err and err_code.
- start in LEN, LOAD, CHK or VERIFY is ignored.
- mem_wr and mem_rd are never high on the same cycle.
- mem_wr is never asserted outside LOAD, and mem_rd never outside VERIFY.
- RAM words at addresses N..DEPTH-1 are never written; they retain their previous contents.
- All outputs are registered.
- Async reset mid-operation aborts immediately to the reset values. A partially written RAM image is not cleaned up.

Test Plan:
1. start; stream 0x03, 0x21, 0x42, 0x63, 0x3A -> mem_wr at addresses 0/1/2 with data 0x21/0x42/0x63, then 3 mem_rd pulses, then cpu_n_rst=1, done=1, err=0.
2. start; length byte 0x00, then separately 0x21 -> err=1, err_code=1, no mem_wr pulses, cpu_n_rst stays 0.
3. Length 0x20 with payload 0x00..0x1F and C=0x10 -> 32 writes at addresses 0..31, no wrap, done=1. Repeat with a wrong C (0x11) -> err_code=2 and no mem_rd.
4. Scenario 1 with the RAM model corrupting address 1 on readback -> err_code=3, cpu_n_rst=0.
5. Scenario 1 with in_valid toggling every other cycle -> identical write sequence and identical final state.
6. In RUN: start with cpu_halt=0 -> ignored. Then start with cpu_halt=1 -> cpu_n_rst=0 and a new load proceeds. Pulse n_rst low mid-LOAD -> all outputs return to reset values in the same cycle.
